// File: rtl/vx_tcu_drl_acc.sv
// Elastic two-stage adder for the TCU DRL FEDP datapath: split lane sums in S1,
// final sum plus sign/zero flags in S2, with bubble-collapsing valid/ready.
module vx_tcu_drl_acc #(
   parameter string INSTANCE_ID = "",
   parameter int    N           = 5,
   parameter int    WA          = 27,
   localparam int   WS          = WA + $clog2(N)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   valid_in,
   output logic                   ready_in,
   input  logic [31:0]            req_id_in,
   input  logic                   is_int_in,
   input  logic [7:0]             exp_in,
   input  logic [N-1:0][WA-1:0]   sigs_in,
   input  logic [N-1:0]           sticky_in,
   output logic                   valid_out,
   input  logic                   ready_out,
   output logic [31:0]            req_id_out,
   output logic                   is_int_out,
   output logic [7:0]             exp_out,
   output logic [WS-1:0]          sum_out,
   output logic                   sticky_out,
   output logic                   sign_out,
   output logic                   zero_out
);

   logic          s1_valid_q, s1_valid_d;
   logic          s2_valid_q, s2_valid_d;
   logic [WS-1:0] s1_lo_q, s1_hi_q;
   logic          s1_st_q, s1_int_q;
   logic [31:0]   s1_id_q;
   logic [7:0]    s1_exp_q;
   logic [WS-1:0] s2_sum_q;
   logic          s2_st_q, s2_int_q, s2_sign_q, s2_zero_q;
   logic [31:0]   s2_id_q;
   logic [7:0]    s2_exp_q;

   logic [WS-1:0] ps_lo_d, ps_hi_d, sum_d;
   logic          st_d;
   logic          s2_adv, s1_adv, fire_in, s2_load;

   assign s2_adv  = ~s2_valid_q | ready_out;
   assign s1_adv  = ~s1_valid_q | s2_adv;
   assign fire_in = valid_in & s1_adv;
   assign s2_load = s2_adv & s1_valid_q;

   // Lanes are sign-extended to WS before summing, so the total cannot overflow.
   always_comb begin
      ps_lo_d = '0;
      ps_hi_d = '0;
      for (int i = 0; i < N; i++) begin
         if (i < N/2)
            ps_lo_d = ps_lo_d + {{(WS-WA){sigs_in[i][WA-1]}}, sigs_in[i]};
         else
            ps_hi_d = ps_hi_d + {{(WS-WA){sigs_in[i][WA-1]}}, sigs_in[i]};
      end
      st_d = (|sticky_in) & ~is_int_in;
   end

   assign sum_d = s1_lo_q + s1_hi_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      if (s1_adv)
         s1_valid_d = fire_in;
      if (s2_adv)
         s2_valid_d = s1_valid_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_lo_q    <= '0;
         s1_hi_q    <= '0;
         s1_st_q    <= 1'b0;
         s1_int_q   <= 1'b0;
         s1_id_q    <= '0;
         s1_exp_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (fire_in) begin
            s1_lo_q  <= ps_lo_d;
            s1_hi_q  <= ps_hi_d;
            s1_st_q  <= st_d;
            s1_int_q <= is_int_in;
            s1_id_q  <= req_id_in;
            s1_exp_q <= exp_in;
         end
      end
   end

   // zero flag resets high so it agrees with the cleared sum register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_st_q    <= 1'b0;
         s2_int_q   <= 1'b0;
         s2_sign_q  <= 1'b0;
         s2_zero_q  <= 1'b1;
         s2_id_q    <= '0;
         s2_exp_q   <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         if (s2_load) begin
            s2_sum_q  <= sum_d;
            s2_st_q   <= s1_st_q;
            s2_int_q  <= s1_int_q;
            s2_sign_q <= sum_d[WS-1];
            s2_zero_q <= (sum_d == '0);
            s2_id_q   <= s1_id_q;
            s2_exp_q  <= s1_exp_q;
         end
      end
   end

   assign ready_in   = s1_adv;
   assign valid_out  = s2_valid_q;
   assign req_id_out = s2_id_q;
   assign is_int_out = s2_int_q;
   assign exp_out    = s2_exp_q;
   assign sum_out    = s2_sum_q;
   assign sticky_out = s2_st_q;
   assign sign_out   = s2_sign_q;
   assign zero_out   = s2_zero_q;

`ifdef DBG_TRACE_TCU
   always_ff @(posedge clk) begin
      if (!reset && fire_in)
         $display("%t: %s acc-in  req_id=%0d sticky=%b", $time, INSTANCE_ID, req_id_in, st_d);
      if (!reset && s2_valid_q && ready_out)
         $display("%t: %s acc-out req_id=%0d sum=0x%0h sticky=%b", $time, INSTANCE_ID,
                  s2_id_q, s2_sum_q, s2_st_q);
   end
`endif

endmodule

// File: tb/tb_vx_tcu_drl_acc.sv
// Directed bench for vx_tcu_drl_acc: single-shot vector table, backpressure
// streams (fixed and random ready_out) and a mid-flight reset pulse.
module tb_vx_tcu_drl_acc;

   logic               clk;
   logic               reset;
   logic               valid_in;
   logic               ready_in;
   logic [31:0]        req_id_in;
   logic               is_int_in;
   logic [7:0]         exp_in;
   logic [4:0][26:0]   sigs;
   logic [4:0]         sticky_in;
   logic               valid_out;
   logic               ready_out;
   logic [31:0]        req_id_out;
   logic               is_int_out;
   logic [7:0]         exp_out;
   logic [29:0]        sum_out;
   logic               sticky_out;
   logic               sign_out;
   logic               zero_out;

   int n_cmp = 0;
   int n_err = 0;

   vx_tcu_drl_acc #(.INSTANCE_ID("tb"), .N(5), .WA(27)) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .ready_in   (ready_in),
      .req_id_in  (req_id_in),
      .is_int_in  (is_int_in),
      .exp_in     (exp_in),
      .sigs_in    (sigs),
      .sticky_in  (sticky_in),
      .valid_out  (valid_out),
      .ready_out  (ready_out),
      .req_id_out (req_id_out),
      .is_int_out (is_int_out),
      .exp_out    (exp_out),
      .sum_out    (sum_out),
      .sticky_out (sticky_out),
      .sign_out   (sign_out),
      .zero_out   (zero_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0][26:0] sigs;
      logic [4:0]       sticky;
      logic             is_int;
      logic [29:0]      sum;
      logic             st;
      logic             sign;
      logic             zero;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [4:0][26:0] lanes(input int l0, input int l1, input int l2,
                                              input int l3, input int l4);
      logic [4:0][26:0] r;
      r[0] = 27'(l0); r[1] = 27'(l1); r[2] = 27'(l2); r[3] = 27'(l3); r[4] = 27'(l4);
      return r;
   endfunction

   function automatic logic [4:0][26:0] stream_lanes(input int id);
      return lanes(id, 2*id, -id, 100*id, 7);
   endfunction

   task automatic run_stream(input bit rnd);
      int idx = 1;
      int got = 0;
      int acc = 0;
      bit stall = 0;
      bit drop_seen = 0;
      int e;
      int q[$];
      logic [31:0] s_id;
      logic [29:0] s_sum;
      for (int c = 0; c < 400 && got < 6; c++) begin
         @(negedge clk);
         if (stall) begin
            check("stall_valid", valid_out, 1);
            check("stall_id", req_id_out, s_id);
            check("stall_sum", sum_out, s_sum);
         end
         ready_out = rnd ? 1'($urandom_range(0, 1)) : !(c >= 2 && c <= 5);
         if (idx <= 6) begin
            valid_in  = 1'b1;
            req_id_in = idx;
            sigs      = stream_lanes(idx);
            sticky_in = 5'(idx & 1);
            is_int_in = 1'b0;
            exp_in    = 8'(idx);
         end else begin
            valid_in = 1'b0;
         end
         #1;
         if (!rnd && !drop_seen && valid_in && !ready_in) begin
            drop_seen = 1;
            check("rdy_drop_after", acc, 2);
         end
         if (valid_out && ready_out) begin
            if (q.size() == 0) begin
               check("unexpected_out", req_id_out, 0);
            end else begin
               e = q.pop_front();
               check("stream_id", req_id_out, e);
               check("stream_sum", sum_out, 30'(102*e + 7));
               check("stream_sticky", sticky_out, e & 1);
               got++;
            end
         end
         if (valid_in && ready_in) begin
            q.push_back(idx);
            idx++;
            acc++;
         end
         stall = valid_out && !ready_out;
         s_id  = req_id_out;
         s_sum = sum_out;
      end
      check("stream_count", got, 6);
      if (!rnd) check("rdy_drop_seen", drop_seen, 1);
   endtask

   initial begin
      vecs[0] = '{lanes(1, 2, 3, 4, 5), 5'b00000, 1'b0, 30'd15, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{lanes(-1, -1, -1, -1, -1), 5'b00100, 1'b0, 30'h3FFFFFFB, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{lanes(-1, -1, -1, -1, -1), 5'b00100, 1'b1, 30'h3FFFFFFB, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{lanes(32'h3FFFFFF, 32'h3FFFFFF, 32'h3FFFFFF, 32'h3FFFFFF, 32'h3FFFFFF),
                  5'b00000, 1'b0, 30'h13FFFFFB, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{lanes(32'h4000000, 32'h4000000, 32'h4000000, 32'h4000000, 32'h4000000),
                  5'b00000, 1'b0, 30'h2C000000, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{lanes(3, -3, 0, 0, 0), 5'b00000, 1'b0, 30'd0, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{lanes(0, 3, 0, 0, -3), 5'b10000, 1'b0, 30'd0, 1'b1, 1'b0, 1'b1};

      reset     = 1'b1;
      valid_in  = 1'b0;
      ready_out = 1'b1;
      req_id_in = '0;
      is_int_in = 1'b0;
      exp_in    = '0;
      sigs      = '0;
      sticky_in = '0;

      @(negedge clk);
      @(negedge clk);
      check("rst_valid", valid_out, 0);
      check("rst_ready_in", ready_in, 1);
      check("rst_sum", sum_out, 0);
      check("rst_zero", zero_out, 1);
      check("rst_sign", sign_out, 0);
      check("rst_sticky", sticky_out, 0);
      check("rst_id", req_id_out, 0);
      check("rst_exp", exp_out, 0);
      check("rst_int", is_int_out, 0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         valid_in  = 1'b1;
         ready_out = 1'b1;
         req_id_in = 32'(100 + i);
         exp_in    = 8'(8'h40 + i);
         sigs      = vecs[i].sigs;
         sticky_in = vecs[i].sticky;
         is_int_in = vecs[i].is_int;
         #1;
         check("vec_ready_in", ready_in, 1);
         @(negedge clk);
         valid_in = 1'b0;
         check("vec_lat1_valid", valid_out, 0);
         @(negedge clk);
         check("vec_valid", valid_out, 1);
         check("vec_sum", sum_out, vecs[i].sum);
         check("vec_sticky", sticky_out, vecs[i].st);
         check("vec_sign", sign_out, vecs[i].sign);
         check("vec_zero", zero_out, vecs[i].zero);
         check("vec_id", req_id_out, 100 + i);
         check("vec_exp", exp_out, 8'h40 + i);
         check("vec_int", is_int_out, vecs[i].is_int);
      end

      run_stream(1'b0);
      run_stream(1'b1);

      // Two requests in flight, then an asynchronous reset between edges.
      @(negedge clk);
      ready_out = 1'b1;
      valid_in  = 1'b1;
      is_int_in = 1'b0;
      sticky_in = '0;
      req_id_in = 32'd201;
      sigs      = stream_lanes(201);
      @(negedge clk);
      req_id_in = 32'd202;
      sigs      = stream_lanes(202);
      @(negedge clk);
      valid_in = 1'b0;
      check("pre_rst_valid", valid_out, 1);
      #2 reset = 1'b1;
      #1;
      check("midrst_valid", valid_out, 0);
      check("midrst_zero", zero_out, 1);
      check("midrst_sum", sum_out, 0);
      check("midrst_ready_in", ready_in, 1);
      #1 reset = 1'b0;
      valid_in  = 1'b1;
      req_id_in = 32'd203;
      sigs      = stream_lanes(203);
      @(negedge clk);
      valid_in = 1'b0;
      check("post_rst_lat1", valid_out, 0);
      @(negedge clk);
      check("post_rst_valid", valid_out, 1);
      check("post_rst_id", req_id_out, 203);
      check("post_rst_sum", sum_out, 30'(102*203 + 7));
      @(negedge clk);
      check("post_rst_alone", valid_out, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vx_tcu_drl_acc.md
Name: VX_tcu_drl_acc

Overview:
- Elastic 2-stage adder stage of the TCU DRL FEDP datapath, directly downstream of the alignment stage.
- Consumes N aligned two's-complement significands (products plus C term) and their per-lane sticky bits.
- Produces one sign-extended sum, a merged sticky bit, and sign/zero flags for the normalise/round stage.
- Carries req_id, exponent and is_int alongside the data, with valid/ready backpressure.

Parameters:
- INSTANCE_ID, "", trace tag.
- N, 5, lane count (N-1 product lanes plus C lane); N >= 2.
- WA, 27, input lane width (two's complement).
- WS, WA + $clog2(N), sum width; derived, not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- valid_in  in  1  upstream data valid
- ready_in  out  1  block can accept this cycle
- req_id_in  in  32  request tag
- is_int_in  in  1  integer mode flag
- exp_in  in  8  aligned (max) exponent
- sigs_in  in  N*WA  lane significands, [N-1:0][WA-1:0]
- sticky_in  in  N  per-lane sticky bits
- valid_out  out  1  result valid
- ready_out  in  1  downstream accepts
- req_id_out  out  32  tag of result
- is_int_out  out  1  forwarded is_int
- exp_out  out  8  forwarded exponent
- sum_out  out  WS  signed sum of all lanes
- sticky_out  out  1  OR of sticky_in; forced 0 when is_int
- sign_out  out  1  sum_out[WS-1]
- zero_out  out  1  sum_out == 0

Behaviour:
- Reset (asynchronous, active-high): s1_valid=0, s2_valid=0; all data registers 0. Outputs during reset: valid_out=0, sum_out=0, sticky_out=0, sign_out=0, zero_out=1, req_id_out=0, exp_out=0, is_int_out=0, ready_in=1.
- Arithmetic: every lane is sign-extended to WS bits before adding. Overflow is impossible by construction. Wrap is not checked.
- Stage 1 (S1), loaded on input fire:
  - ps_lo = sum of lanes 0..N/2-1.
  - ps_hi = sum of lanes N/2..N-1.
  - st = |sticky_in & ~is_int_in.
  - req_id, exp and is_int are registered.
- Stage 2 (S2), loaded from S1:
  - sum = ps_lo + ps_hi.
  - sign/zero derived from sum and registered with it; S2 registers drive the outputs directly.
- Handshake (bubble-collapsing):
  - s2_adv = ~s2_valid | ready_out.
  - s1_adv = ~s1_valid | s2_adv.
  - ready_in = s1_adv (combinational from ready_out; no combinational valid→ready path).
  - Input fires when valid_in & ready_in; S1 loads and s1_valid <= 1.
  - If s1_adv and there is no input fire, s1_valid <= 0.
  - S2 loads when s2_adv & s1_valid (s2_valid <= 1). When s2_adv & ~s1_valid, s2_valid <= 0.
  - A stalled stage holds its data and valid unchanged.
- Latency: 2 cycles (input fire at edge k gives valid_out high after edge k+1). Throughput 1/cycle while ready_out=1. Holds up to 2 requests in flight.
- Ordering: strictly in order; no drop or duplication under any ready_out pattern.
- valid_out and all output data are stable while valid_out & ~ready_out.
- Simultaneous S2 drain, S1→S2 move and new input in the same cycle are all legal.
- Reset asserted mid-operation discards in-flight requests immediately. The first valid_in after deassertion is accepted on the next edge.
- DBG_TRACE_TCU: trace each input fire and each output fire with req_id, sum and sticky.

Test Plan:
- N=5, WA=27, lanes {1,2,3,4,5}, sticky=0, ready_out=1 → valid_out two cycles after fire; sum_out=15, sign=0, zero=0, sticky=0.
- All lanes 27'h7FFFFFF (-1), sticky=5'b00100, is_int=0 → sum_out=30'h3FFFFFFB, sign=1, sticky=1. Same stimulus with is_int=1 → sticky_out=0.
- Extremes: all lanes 27'h3FFFFFF → sum_out=30'h13FFFFFB. All lanes 27'h4000000 → sum_out=30'h2C000000, sign=1.
- Lanes {3,-3,0,0,0}, sticky=0 → sum_out=0, zero=1.
- Backpressure: stream req_id 1..6 back-to-back with ready_out=0 for cycles 2–5. Required response:
  - ready_in drops after 2 accepted requests.
  - Outputs stay stable during the stall.
  - Results emerge in order 1..6 with correct sums.
  - Random ready_out toggling yields the same sequence.
- Reset pulse asserted between edges with 2 requests in flight → valid_out=0 and zero_out=1 immediately, before the next edge. A request sent after reset emerges alone with its correct sum.
